// File: rtl/matrix_mac_seq.sv
// matrix_mac_seq: sequential NxN element-wise (op=0) / matrix-product (op=1) engine on one multiplier.
// Optional MATRIX_ACC_EN adds in_acc, which accumulates the new result into the existing C register.
module matrix_mac_seq #(
    parameter  int unsigned W  = 8,
    parameter  int unsigned N  = 2,
    localparam int unsigned CW = 2*W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
`ifdef MATRIX_ACC_EN
    input  logic              in_acc,
`endif
    input  logic [N*N*W-1:0]  a_flat,
    input  logic [N*N*W-1:0]  b_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*CW-1:0] c_flat
);
    localparam int unsigned   IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  a_in [N][N];
    logic [W-1:0]  b_in [N][N];
    logic [W-1:0]  a_q  [N][N];
    logic [W-1:0]  b_q  [N][N];
    logic [CW-1:0] c_q  [N][N];
    logic [CW-1:0] acc_q;
    logic [IW-1:0] i_q, j_q, k_q;
    logic          op_q;
`ifdef MATRIX_ACC_EN
    logic          acc_mode_q;
`endif

    logic [W-1:0]  a_el_c, b_el_c;
    logic [CW-1:0] prod_c, sum_c, elem_c;
    logic          i_last_c, j_last_c, k_last_c, last_c, write_c, accept_c;

    // Flat bus <-> element array mapping, element (i,j) at index i*N+j
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign a_in[gi][gj] = a_flat[(gi*N+gj)*W +: W];
            assign b_in[gi][gj] = b_flat[(gi*N+gj)*W +: W];
            assign c_flat[(gi*N+gj)*CW +: CW] = c_q[gi][gj];
        end
    end

    // Operand select, single multiplier and the value written into C[i][j]
    always_comb begin
        a_el_c   = a_q[i_q][op_q ? k_q : j_q];
        b_el_c   = b_q[op_q ? k_q : i_q][j_q];
        prod_c   = CW'(a_el_c) * CW'(b_el_c);
        sum_c    = acc_q + prod_c;
        elem_c   = op_q ? sum_c : prod_c;
`ifdef MATRIX_ACC_EN
        if (acc_mode_q) elem_c = elem_c + c_q[i_q][j_q];
`endif
        i_last_c = (i_q == LAST);
        j_last_c = (j_q == LAST);
        k_last_c = (k_q == LAST);
        last_c   = i_last_c && j_last_c && (!op_q || k_last_c);
        write_c  = (state == RUN) && (!op_q || k_last_c);
        accept_c = (state == IDLE) && in_valid;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_c)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register; handshake outputs follow the next state so they are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Operand capture, loop counters, accumulator and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            op_q  <= 1'b0;
`ifdef MATRIX_ACC_EN
            acc_mode_q <= 1'b0;
`endif
        end else if (accept_c) begin
            a_q   <= a_in;
            b_q   <= b_in;
            op_q  <= op;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
`ifdef MATRIX_ACC_EN
            acc_mode_q <= in_acc;
            if (!in_acc) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) c_q[r][c] <= '0;
            end
`else
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) c_q[r][c] <= '0;
`endif
        end else if (state == RUN) begin
            if (write_c) c_q[i_q][j_q] <= elem_c;
            if (op_q) acc_q <= k_last_c ? '0 : sum_c;
            // k innermost for matrix product; element-wise mode never moves k
            if (op_q && !k_last_c) begin
                k_q <= k_q + 1'b1;
            end else begin
                k_q <= '0;
                if (!j_last_c) begin
                    j_q <= j_q + 1'b1;
                end else begin
                    j_q <= '0;
                    i_q <= i_last_c ? '0 : i_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_mac_seq.sv
// tb_matrix_mac_seq: table vectors, hand-written handshake/reset sequences and randomized
// transactions compared against a sum-of-products reference model.
module tb_matrix_mac_seq;
    localparam int unsigned W   = 8;
    localparam int unsigned N   = 2;
    localparam int unsigned CW  = 2*W + $clog2(N);
    localparam int unsigned AW  = N*N*W;
    localparam int unsigned CWT = N*N*CW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, op, out_valid, out_ready;
    logic           in_acc;
    logic [AW-1:0]  a_flat, b_flat;
    logic [CWT-1:0] c_flat;

    int unsigned pass_cnt = 0;
    int unsigned total    = 0;
    logic [CWT-1:0] c_prev = '0;

    always #5 clk = ~clk;

    matrix_mac_seq #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
`ifdef MATRIX_ACC_EN
        .in_acc(in_acc),
`endif
        .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid), .out_ready(out_ready),
        .c_flat(c_flat)
    );

    typedef struct packed {
        logic           op;
        logic [AW-1:0]  a;
        logic [AW-1:0]  b;
        logic [CWT-1:0] c;
        logic [7:0]     lat;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: C = A .* B or C = A x B from plain sums, optionally added onto the previous C
    function automatic logic [CWT-1:0] model(input logic opm, input logic [AW-1:0] a,
                                             input logic [AW-1:0] b, input logic accm,
                                             input logic [CWT-1:0] prev);
        logic [CWT-1:0] res = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint unsigned s = 0;
                if (opm) begin
                    for (int k = 0; k < N; k++)
                        s += longint'(a[(i*N+k)*W +: W]) * longint'(b[(k*N+j)*W +: W]);
                end else begin
                    s = longint'(a[(i*N+j)*W +: W]) * longint'(b[(i*N+j)*W +: W]);
                end
                if (accm) s += longint'(prev[(i*N+j)*CW +: CW]);
                res[(i*N+j)*CW +: CW] = CW'(s);
            end
        end
        return res;
    endfunction

    task automatic run_txn(input string tag, input logic op_i, input logic acc_i,
                           input logic [AW-1:0] a_i, input logic [AW-1:0] b_i,
                           input logic [CWT-1:0] exp_c, input int unsigned exp_lat);
        int unsigned lat = 0;
        logic ready_low = 1'b1;
        @(negedge clk);
        chk({tag, " in_ready before accept"}, 128'(in_ready), 128'(1));
        op = op_i; in_acc = acc_i; a_flat = a_i; b_flat = b_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a_flat = ~a_i; b_flat = ~b_i; op = ~op_i;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ready_low = 1'b0;
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " in_ready low while busy"}, 128'(ready_low), 128'(1));
        chk({tag, " c_flat"}, 128'(c_flat), 128'(exp_c));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " in_ready after release"}, 128'(in_ready), 128'(1));
        chk({tag, " out_valid after release"}, 128'(out_valid), 128'(0));
        c_prev = exp_c;
    endtask

    initial begin
        vec_t tbl[4];
        logic [AW-1:0]  a12 = {8'd4, 8'd3, 8'd2, 8'd1};
        logic [AW-1:0]  b56 = {8'd8, 8'd7, 8'd6, 8'd5};
        logic [AW-1:0]  ff  = {AW{1'b1}};
        logic [CWT-1:0] mm  = {17'd50, 17'd43, 17'd22, 17'd19};
        logic [CWT-1:0] held;
        int unsigned    wait_cnt;

        tbl[0] = '{op: 1'b1, a: a12, b: b56, c: mm, lat: 8'd8};
        tbl[1] = '{op: 1'b0, a: a12, b: b56, c: {17'd32, 17'd21, 17'd12, 17'd5}, lat: 8'd4};
        tbl[2] = '{op: 1'b1, a: ff, b: ff, c: {4{17'd130050}}, lat: 8'd8};
        tbl[3] = '{op: 1'b0, a: ff, b: ff, c: {4{17'd65025}}, lat: 8'd4};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; in_acc = 1'b0;
        a_flat = '0; b_flat = '0;
        #12;
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset c_flat", 128'(c_flat), 128'(0));
        @(negedge clk); rst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            run_txn($sformatf("vec%0d", v), tbl[v].op, 1'b0, tbl[v].a, tbl[v].b, tbl[v].c,
                    int'(tbl[v].lat));

`ifdef MATRIX_ACC_EN
        run_txn("acc base", 1'b1, 1'b0, a12, b56, mm, 8);
        run_txn("acc add", 1'b1, 1'b1, a12, b56, {17'd100, 17'd86, 17'd44, 17'd38}, 8);
        run_txn("acc clear", 1'b1, 1'b0, a12, b56, mm, 8);
`endif

        // Backpressure: DONE holds with out_ready low while in_valid pulses
        @(negedge clk);
        op = 1'b0; a_flat = a12; b_flat = b56; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
        held = {17'd32, 17'd21, 17'd12, 17'd5};
        chk("bp result", 128'(c_flat), 128'(held));
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; op = 1'b1; a_flat = ff; b_flat = ff;
            @(posedge clk); #1;
            chk($sformatf("bp hold out_valid %0d", c), 128'(out_valid), 128'(1));
            chk($sformatf("bp hold c_flat %0d", c), 128'(c_flat), 128'(held));
            chk($sformatf("bp hold in_ready %0d", c), 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp in_ready after release", 128'(in_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("bp no stray accept", 128'({in_ready, out_valid}), 128'(2'b10));
        c_prev = held;

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        op = 1'b1; a_flat = a12; b_flat = b56; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid-run c_flat partially written", 128'(c_flat != '0), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 128'(out_valid), 128'(0));
        chk("async reset c_flat", 128'(c_flat), 128'(0));
        chk("async reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk); rst_n = 1'b1;
        c_prev = '0;
        run_txn("post reset", 1'b1, 1'b0, a12, b56, mm, 8);

        // Randomized transactions against the reference model
        for (int t = 0; t < 24; t++) begin
            logic           r_op  = 1'($urandom);
            logic [AW-1:0]  r_a   = AW'($urandom);
            logic [AW-1:0]  r_b   = AW'($urandom);
            logic           r_acc = 1'b0;
`ifdef MATRIX_ACC_EN
            r_acc = 1'($urandom);
`endif
            run_txn($sformatf("rand%0d", t), r_op, r_acc, r_a, r_b,
                    model(r_op, r_a, r_b, r_acc, c_prev), r_op ? N*N*N : N*N);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
